bht_update_ctrl: RTL

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

---
 rtl/bht_update_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bht_update_ctrl.sv
// Branch history table controller: 32-entry init sweep, priority prediction reads and a small
// queue of 2-bit counter updates. Define BHT_CTRL_BYPASS_EN to forward same-cycle write data.
module bht_update_ctrl #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [1:0]  INIT_VAL   = 2'b01
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       pred_req,
    input  logic [4:0] pred_addr,
    output logic       pred_valid,
    output logic       pred_taken,
    input  logic       upd_valid,
    input  logic [4:0] upd_addr,
    input  logic       upd_taken,
    output logic       upd_ready,
    output logic       init_done,
    output logic       rd_csb,
    output logic [4:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       wr_csb,
    output logic [4:0] wr_addr,
    output logic [1:0] wr_data
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] QDEPTH = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [1:0] {StInit, StIdle, StUpdRd, StUpdWr} state_t;

    state_t           state_q;
    logic [4:0]       init_idx_q;
    logic             init_done_q;
    logic             pred_valid_q;
    logic             pred_init_q;
    logic             rd_ok_q;
    logic [4:0]       q_addr [FIFO_DEPTH];
    logic             q_taken [FIFO_DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
`ifdef BHT_CTRL_BYPASS_EN
    logic             byp_hit_q;
    logic             byp_bit_q;
`endif

    logic       pred_rd;
    logic       upd_rd;
    logic       pop;
    logic       push;
    logic       wr_en;
    logic [1:0] sat_val;

    assign pred_rd = pred_req && (state_q != StInit);
    assign upd_rd  = (state_q == StUpdRd);
    // A prediction that lands in UPD_RD steals the port; the following UPD_WR then skips the
    // write and the FSM retries the same head entry.
    assign pop     = (state_q == StUpdWr) && rd_ok_q;
    assign wr_en   = !arst && ((state_q == StInit) || pop);

    assign upd_ready  = init_done_q && ((count_q != QDEPTH) || pop);
    assign push       = upd_valid && upd_ready;
    assign init_done  = init_done_q;
    assign pred_valid = pred_valid_q;
    assign rd_csb     = !(pred_rd || upd_rd);
    assign wr_csb     = !wr_en;

`ifdef BHT_CTRL_BYPASS_EN
    assign pred_taken = pred_valid_q && !pred_init_q && (byp_hit_q ? byp_bit_q : rd_data[1]);
`else
    assign pred_taken = pred_valid_q && !pred_init_q && rd_data[1];
`endif

    always_comb begin
        sat_val = rd_data;
        if (q_taken[head_q]) begin
            if (rd_data != 2'b11) sat_val = rd_data + 2'b01;
        end else if (rd_data != 2'b00) begin
            sat_val = rd_data - 2'b01;
        end
    end

    always_comb begin
        rd_addr = '0;
        if (pred_rd) rd_addr = pred_addr;
        else if (upd_rd) rd_addr = q_addr[head_q];
    end

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (wr_en) begin
            if (state_q == StInit) begin
                wr_addr = init_idx_q;
                wr_data = INIT_VAL;
            end else begin
                wr_addr = q_addr[head_q];
                wr_data = sat_val;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= StInit;
            init_idx_q   <= '0;
            init_done_q  <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_init_q  <= 1'b0;
            rd_ok_q      <= 1'b0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_addr[i]  <= '0;
                q_taken[i] <= 1'b0;
            end
`ifdef BHT_CTRL_BYPASS_EN
            byp_hit_q    <= 1'b0;
            byp_bit_q    <= 1'b0;
`endif
        end else begin
            pred_valid_q <= pred_req;
            pred_init_q  <= (state_q == StInit);
`ifdef BHT_CTRL_BYPASS_EN
            byp_hit_q    <= pred_rd && wr_en && (wr_addr == pred_addr);
            byp_bit_q    <= wr_data[1];
`endif
            if (push) begin
                q_addr[tail_q]  <= upd_addr;
                q_taken[tail_q] <= upd_taken;
                tail_q          <= tail_q + PTR_ONE;
            end
            if (pop) head_q <= head_q + PTR_ONE;
            if (push && !pop) count_q <= count_q + CNT_ONE;
            else if (pop && !push) count_q <= count_q - CNT_ONE;

            unique case (state_q)
                StInit: begin
                    init_idx_q <= init_idx_q + 5'd1;
                    if (init_idx_q == 5'd31) begin
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                StIdle: if ((count_q != '0) && !pred_req) state_q <= StUpdRd;
                StUpdRd: begin
                    rd_ok_q <= !pred_req;
                    state_q <= StUpdWr;
                end
                StUpdWr: state_q <= StIdle;
                default: state_q <= StInit;
            endcase
        end
    end

endmodule
